// File: rtl/spi_master_multi.sv
`timescale 1ns/1ps
// Parametrised SPI master: configurable width, SCLK divider, per-transfer CPOL/CPHA
// and bit order, NUM_CS active-low selects, start/busy/done host handshake.
module spi_master_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4,
    parameter int NUM_CS     = 4,
    parameter int CS_SEL_W   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CS_SEL_W-1:0]   cs_sel,
    input  logic                  polarity,
    input  logic                  phase,
    input  logic                  lsb_first,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  miso,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  spi_clk,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  mosi,
    output logic [2:0]            state,
    output logic [5:0]            count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_XFER  = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]        EDGE_LAST = 6'(2 * DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [5:0]            edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
    logic                  sclk_q, sclk_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;

    logic                  tick;
    logic                  leading;
    logic                  last_edge;
    logic [DATA_WIDTH-1:0] shifted;
    logic [NUM_CS-1:0]     cs_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_rd_q <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= '1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            data_rd_q <= data_rd_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        data_rd_d = data_rd_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;

        tick      = (div_q == DIV_LAST);
        leading   = ~edge_q[0];
        last_edge = (edge_q == EDGE_LAST);
        shifted   = lsb_q ? (tx_q >> 1) : (tx_q << 1);

        // Out-of-range selects decode to no active line; the transfer still clocks.
        cs_dec = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            cs_dec[i] = (32'(cs_sel) != i);
        end

        unique case (state_q)
            S_IDLE: begin
                sclk_d = polarity;
                if (start) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cpol_d  = polarity;
                    cpha_d  = phase;
                    lsb_d   = lsb_first;
                    tx_d    = data_wr;
                    rx_d    = '0;
                    edge_d  = '0;
                    div_d   = '0;
                    cs_n_d  = cs_dec;
                    mosi_d  = lsb_first ? data_wr[0] : data_wr[DATA_WIDTH-1];
                end
            end
            S_SETUP: begin
                sclk_d = cpol_q;
                div_d  = tick ? '0 : div_q + 1'b1;
                if (tick) state_d = S_XFER;
            end
            S_XFER: begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (cpha_q ? !leading : leading) begin
                        rx_d = lsb_q ? {miso, rx_q[DATA_WIDTH-1:1]}
                                     : {rx_q[DATA_WIDTH-2:0], miso};
                    end
                    // CPHA=0 already presented bit 0 in SETUP, so it drives the bit after the shift.
                    if (cpha_q ? leading : (!leading && !last_edge)) begin
                        tx_d   = shifted;
                        mosi_d = cpha_q ? (lsb_q ? tx_q[0] : tx_q[DATA_WIDTH-1])
                                        : (lsb_q ? shifted[0] : shifted[DATA_WIDTH-1]);
                    end
                    if (last_edge) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                sclk_d = cpol_q;
                div_d  = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    state_d = S_DONE;
                    cs_n_d  = '1;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                done_d    = 1'b1;
                data_rd_d = rx_q;
                busy_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign data_rd = data_rd_q;
    assign spi_clk = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;
    assign state   = state_q;
    assign count   = edge_q;

endmodule

// File: tb/tb_spi_master_multi.sv
`timescale 1ns/1ps
// Directed bench for spi_master_multi: behavioural SPI slave on the bus, immediate
// assertions on latency, received/transmitted words, selects and abort behaviour.
module tb_spi_master_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] cs_sel = '0;
    logic       polarity = 1'b0;
    logic       phase = 1'b0;
    logic       lsb_first = 1'b0;
    logic [7:0] data_wr = '0;
    logic       miso = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] data_rd;
    logic       spi_clk;
    logic [3:0] cs_n;
    logic       mosi;
    logic [2:0] state;
    logic [5:0] count;

    int checks = 0;
    int failures = 0;

    spi_master_multi #(
        .DATA_WIDTH(8),
        .CLK_DIV(4),
        .NUM_CS(4),
        .CS_SEL_W(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cs_sel(cs_sel),
        .polarity(polarity), .phase(phase), .lsb_first(lsb_first),
        .data_wr(data_wr), .miso(miso), .busy(busy), .done(done),
        .data_rd(data_rd), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi),
        .state(state), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural slave and bus monitor
    logic       slave_en = 1'b0;
    logic       cpol_t = 1'b0;
    logic       cpha_t = 1'b0;
    logic       lsb_t = 1'b0;
    logic [7:0] s_word = '0;
    int         s_idx = 0;
    int         rise_cnt = 0;
    int         edge_tot = 0;
    logic [7:0] mosi_word = '0;
    int         mosi_cnt = 0;
    int         done_cnt = 0;

    function automatic logic s_bit(input int k);
        logic [7:0] w;
        w = s_word;
        return lsb_t ? w[k] : w[7-k];
    endfunction

    always @(spi_clk) begin
        if (slave_en) begin
            edge_tot++;
            if (spi_clk) rise_cnt++;
            if ((spi_clk != cpol_t) == !cpha_t) begin
                mosi_word = {mosi_word[6:0], mosi};
                mosi_cnt++;
            end else if (!cpha_t) begin
                s_idx++;
                if (s_idx < 8) miso = s_bit(s_idx);
            end else begin
                if (s_idx < 8) miso = s_bit(s_idx);
                s_idx++;
            end
        end
    end

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prep(input logic pol, input logic pha, input logic lsb,
                        input logic [2:0] sel, input logic [7:0] dwr, input logic [7:0] sw);
        @(negedge clk);
        slave_en = 1'b0;
        polarity = pol; phase = pha; lsb_first = lsb; cs_sel = sel; data_wr = dwr;
        cpol_t = pol; cpha_t = pha; lsb_t = lsb; s_word = sw;
        repeat (2) @(negedge clk);
        s_idx = 0;
        miso = pha ? 1'b0 : s_bit(0);
        rise_cnt = 0; edge_tot = 0; mosi_word = '0; mosi_cnt = 0;
        slave_en = 1'b1;
    endtask

    task automatic launch;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int poke_at, output int lat, output logic [3:0] cs_mid);
        lat = 0;
        cs_mid = 'x;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk("busy_after_accept", 32'(busy), 32'd1);
            if (start) start = 1'b0;
            if (lat == poke_at) begin
                data_wr = 8'h55;
                start = 1'b1;
            end
            if (lat == 20) cs_mid = cs_n;
            if (done) break;
        end
        start = 1'b0;
    endtask

    int         lat;
    logic [3:0] cs_mid;
    int         dc0;
    int         k;
    logic [1:0] mv;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data_rd", 32'(data_rd), 32'd0);
        chk("rst_spi_clk", 32'(spi_clk), 32'd0);
        chk("rst_cs_n", 32'(cs_n), 32'hF);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        reset = 1'b0;

        // Mode 0, MSB first
        prep(1'b0, 1'b0, 1'b0, 3'd0, 8'hCA, 8'hAF);
        dc0 = done_cnt;
        launch();
        wait_done(0, lat, cs_mid);
        chk("m0_latency", 32'(lat), 32'd73);
        chk("m0_data_rd", 32'(data_rd), 32'hAF);
        chk("m0_mosi_word", 32'(mosi_word), 32'hCA);
        chk("m0_mosi_bits", 32'(mosi_cnt), 32'd8);
        chk("m0_rising", 32'(rise_cnt), 32'd8);
        chk("m0_cs_mid", 32'(cs_mid), 32'hE);
        chk("m0_cs_end", 32'(cs_n), 32'hF);
        chk("m0_busy_end", 32'(busy), 32'd0);
        chk("m0_count", 32'(count), 32'd16);
        repeat (3) @(posedge clk);
        #1;
        chk("m0_one_done", 32'(done_cnt - dc0), 32'd1);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            mv = 2'(m);
            prep(mv[1], mv[0], 1'b0, 3'd0, 8'hCA, 8'hAF);
            chk("mode_idle_sclk", 32'(spi_clk), 32'(mv[1]));
            launch();
            wait_done(0, lat, cs_mid);
            chk("mode_latency", 32'(lat), 32'd73);
            chk("mode_data_rd", 32'(data_rd), 32'hAF);
            chk("mode_mosi_word", 32'(mosi_word), 32'hCA);
            chk("mode_edges", 32'(edge_tot), 32'd16);
            chk("mode_sclk_end", 32'(spi_clk), 32'(mv[1]));
        end

        // LSB first
        prep(1'b0, 1'b0, 1'b1, 3'd0, 8'hCA, 8'hAF);
        launch();
        wait_done(0, lat, cs_mid);
        chk("lsb_latency", 32'(lat), 32'd73);
        chk("lsb_data_rd", 32'(data_rd), 32'hAF);
        chk("lsb_mosi_seq", 32'(mosi_word), 32'h53);

        // Start pulsed mid-XFER is ignored
        prep(1'b0, 1'b0, 1'b0, 3'd0, 8'hCA, 8'hAF);
        dc0 = done_cnt;
        launch();
        wait_done(30, lat, cs_mid);
        chk("busy_start_latency", 32'(lat), 32'd73);
        chk("busy_start_data_rd", 32'(data_rd), 32'hAF);
        chk("busy_start_mosi", 32'(mosi_word), 32'hCA);
        repeat (5) @(posedge clk);
        #1;
        chk("busy_start_one_done", 32'(done_cnt - dc0), 32'd1);
        chk("busy_start_idle", 32'(state), 32'd0);
        chk("busy_start_not_busy", 32'(busy), 32'd0);

        // Reset at XFER edge 5
        prep(1'b0, 1'b0, 1'b0, 3'd1, 8'hCA, 8'hAF);
        dc0 = done_cnt;
        launch();
        k = 0;
        while (count != 6'd5 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("abort_reach_edge5", 32'(count), 32'd5);
        chk("abort_cs_before", 32'(cs_n), 32'hD);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_cs_n", 32'(cs_n), 32'hF);
        chk("abort_spi_clk", 32'(spi_clk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        prep(1'b1, 1'b1, 1'b0, 3'd2, 8'h3C, 8'h96);
        launch();
        wait_done(0, lat, cs_mid);
        chk("after_abort_latency", 32'(lat), 32'd73);
        chk("after_abort_data_rd", 32'(data_rd), 32'h96);
        chk("after_abort_mosi", 32'(mosi_word), 32'h3C);
        chk("after_abort_cs_mid", 32'(cs_mid), 32'hB);

        // Chip-select range
        prep(1'b0, 1'b0, 1'b0, 3'd3, 8'hCA, 8'hAF);
        launch();
        wait_done(0, lat, cs_mid);
        chk("sel3_cs_mid", 32'(cs_mid), 32'h7);
        chk("sel3_data_rd", 32'(data_rd), 32'hAF);
        prep(1'b0, 1'b0, 1'b0, 3'd5, 8'hCA, 8'h5A);
        dc0 = done_cnt;
        launch();
        wait_done(0, lat, cs_mid);
        chk("sel5_cs_mid", 32'(cs_mid), 32'hF);
        chk("sel5_edges", 32'(edge_tot), 32'd16);
        chk("sel5_latency", 32'(lat), 32'd73);
        chk("sel5_data_rd", 32'(data_rd), 32'h5A);
        repeat (2) @(posedge clk);
        #1;
        chk("sel5_done", 32'(done_cnt - dc0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master and successor to the fixed 8-bit SPI block. Supports:
- configurable word width and SCLK divider;
- all four CPOL/CPHA modes, selected per transfer;
- MSB- or LSB-first shifting;
- NUM_CS independent active-low chip selects;
- start/busy/done handshake to the host logic.

It sits between on-chip control logic and external SPI slaves.

Parameters:
DATA_WIDTH, 8, bits per transfer (2..32)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
NUM_CS, 4, number of chip-select outputs (1..16)
CS_SEL_W, 2, width of cs_sel (>= clog2(NUM_CS), min 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; accepted only in IDLE
cs_sel  in  CS_SEL_W  target slave index
polarity  in  1  CPOL for this transfer
phase  in  1  CPHA for this transfer
lsb_first  in  1  1 = shift LSB first
data_wr  in  DATA_WIDTH  word to transmit
miso  in  1  serial data from slave
busy  out  1  high from the cycle after start acceptance until DONE exits
done  out  1  one-cycle pulse; data_rd is valid in that cycle
data_rd  out  DATA_WIDTH  last received word, held until the next done
spi_clk  out  1  SCLK
cs_n  out  NUM_CS  active-low selects, one-hot-low during a transfer
mosi  out  1  serial data to slave
state  out  3  debug: IDLE=0, SETUP=1, XFER=2, HOLD=3, DONE=4
count  out  6  debug: SCLK edges issued in the current transfer

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, data_rd=0, spi_clk=0, cs_n=all 1, mosi=0, count=0, divider=0. Reset asserted mid-transfer aborts on the next edge to exactly these values; no done pulse is produced.
- IDLE:
  - spi_clk is registered from the polarity input, so it follows CPOL with one cycle of latency.
  - On start=1: latch cs_sel, polarity, phase, lsb_first and data_wr into shadow registers, then go to SETUP. Later changes to these inputs have no effect on the transfer in progress.
- SETUP (CLK_DIV cycles):
  - cs_n[cs_sel] driven low.
  - mosi = first bit (MSB, or LSB if lsb_first); meaningful only for CPHA=0.
  - spi_clk held at CPOL.
  - If cs_sel >= NUM_CS, all cs_n stay high and the transfer still runs (dummy clocks); data_rd is updated normally.
- XFER (2*DATA_WIDTH*CLK_DIV cycles):
  - The divider counts 0..CLK_DIV-1. At terminal count, spi_clk toggles and count increments.
  - Edges 1,3,5,... are leading; edges 2,4,... are trailing.
  - CPHA=0: sample miso on leading edges; drive the next bit on trailing edges except the final (2*DATA_WIDTH-th) edge.
  - CPHA=1: drive a bit on each leading edge (first bit on edge 1); sample miso on trailing edges.
  - Received bits are assembled in the same order as transmitted: with lsb_first the first sampled bit lands in bit 0, otherwise in the MSB.
  - After edge 2*DATA_WIDTH, spi_clk equals CPOL; go to HOLD.
- HOLD (CLK_DIV cycles): cs_n still asserted and spi_clk=CPOL. On exit, all cs_n go high.
- DONE (1 cycle): done=1, data_rd=shift register, busy=0 on exit, then return to IDLE.
  - A start asserted while in DONE is ignored.
  - Back-to-back transfers need start in the following IDLE cycle.
- start while busy is ignored, with no queuing.
- Latency: done is asserted (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after the start-accept edge. This is 73 cycles for 8/4.
- mosi holds its last value outside XFER/SETUP and returns to 0 on reset.

Test Plan:
1. Mode 0 (polarity=0, phase=0), cs_sel=0, data_wr=0xCA, miso presents 0xAF MSB-first on leading edges -> mosi sequence 1,1,0,0,1,0,1,0; cs_n=4'b1110 during the transfer; data_rd=0xAF with done 73 cycles after start; 8 rising SCLK edges.
2. Repeat with modes 1, 2 and 3 and the same data -> data_rd=0xAF each time; idle SCLK=1 for modes 2/3; in modes 1/3 mosi changes on leading edges and miso is sampled on trailing edges.
3. lsb_first=1, data_wr=0xCA, miso bits 1,1,1,1,0,1,0,1 -> mosi sequence 0,1,0,1,0,0,1,1; data_rd=0xAF.
4. Second start pulsed mid-XFER with data_wr=0x55 -> ignored; the first transfer completes with its original data, and exactly one done pulse occurs.
5. reset asserted at edge 5 of XFER -> next cycle all cs_n high, spi_clk=0, busy=0, state=0, no done; a new transfer afterwards completes correctly.
6. cs_sel=3 vs cs_sel=5 with NUM_CS=4, CS_SEL_W=3 -> cs_n=4'b0111 for the first; all high but 16 SCLK edges for the second, with done still pulsing.
